// File: rtl/icache_controller_pkg.sv
// Shared geometry, address field positions and FSM encoding for the instruction cache.
package icache_controller_pkg;

  localparam int unsigned TAG_MSB    = 9;
  localparam int unsigned TAG_LSB    = 7;
  localparam int unsigned INDEX_MSB  = 6;
  localparam int unsigned INDEX_LSB  = 4;
  localparam int unsigned OFFSET_MSB = 3;
  localparam int unsigned OFFSET_LSB = 2;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned NUM_BLOCKS = 8;
  localparam int unsigned TAG_W      = TAG_MSB - TAG_LSB + 1;
  localparam int unsigned INDEX_W    = INDEX_MSB - INDEX_LSB + 1;
  localparam int unsigned BADDR_W    = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMemRead = 2'd1,
    StUpdate  = 2'd2
  } state_e;

endpackage

// File: rtl/icache_tag_compare.sv
// Hit detection for one cache line: valid and matching tag.
module icache_tag_compare
  import icache_controller_pkg::*;
(
  input  logic             valid_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0] addr_tag_i,
  output logic             hit_o
);

  assign hit_o = valid_i && (tag_i == addr_tag_i);

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: 8 blocks x 4 words, block refill on miss.
module icache_controller
  import icache_controller_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               read,
  input  logic [9:0]         address,
  output logic               busywait,
  output logic [31:0]        ins_word0,
  output logic [31:0]        ins_word1,
  output logic [31:0]        ins_word2,
  output logic [31:0]        ins_word3,
  output logic [1:0]         offset,
  output logic               mem_read,
  output logic [BADDR_W-1:0] mem_address,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);

  state_e               state_q, state_d;
  logic [BADDR_W-1:0]   miss_addr_q, miss_addr_d;
  logic [BLOCK_W-1:0]   fill_buf_q, fill_buf_d;
  logic                 first_q;  // set on the entry cycle of MemRead; blocks an early exit
  logic                 write_en;
  logic [BLOCK_W-1:0]   data_q [NUM_BLOCKS];
  logic [TAG_W-1:0]     tag_q  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_q;

  logic [TAG_W-1:0]     addr_tag;
  logic [INDEX_W-1:0]   addr_index;
  logic [INDEX_W-1:0]   fill_index;
  logic                 hit;
  logic                 unused_addr_lsb;

  assign addr_tag        = address[TAG_MSB:TAG_LSB];
  assign addr_index      = address[INDEX_MSB:INDEX_LSB];
  assign fill_index      = miss_addr_q[INDEX_W-1:0];
  assign unused_addr_lsb = ^address[1:0];

  icache_tag_compare u_tag_compare (
    .valid_i    (valid_q[addr_index]),
    .tag_i      (tag_q[addr_index]),
    .addr_tag_i (addr_tag),
    .hit_o      (hit)
  );

  // Words of the indexed block go to the downstream selector regardless of state.
  assign ins_word0 = data_q[addr_index][31:0];
  assign ins_word1 = data_q[addr_index][63:32];
  assign ins_word2 = data_q[addr_index][95:64];
  assign ins_word3 = data_q[addr_index][127:96];
  assign offset    = address[OFFSET_MSB:OFFSET_LSB];

  // Next-state and outputs of the miss-handling FSM.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    fill_buf_d  = fill_buf_q;
    busywait    = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    write_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (read && !hit) begin
          busywait    = 1'b1;
          miss_addr_d = address[TAG_MSB:INDEX_LSB];
          state_d     = StMemRead;
        end
      end
      StMemRead: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = miss_addr_q;
        if (!first_q && !mem_busywait) begin
          fill_buf_d = mem_readdata;
          state_d    = StUpdate;
        end
      end
      StUpdate: begin
        busywait = 1'b1;
        write_en = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (RESET) busywait = 1'b0;
  end

  // Control state, miss latch, fill buffer and valid bits; reset aborts any fill.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
      fill_buf_q  <= '0;
      first_q     <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      fill_buf_q  <= fill_buf_d;
      first_q     <= (state_q == StIdle) && (state_d == StMemRead);
      if (write_en) valid_q[fill_index] <= 1'b1;
    end
  end

  // Data and tag arrays are not cleared by reset; written only in Update.
  always_ff @(posedge CLK) begin
    if (write_en && !RESET) begin
      data_q[fill_index] <= fill_buf_q;
      tag_q[fill_index]  <= miss_addr_q[BADDR_W-1:INDEX_W];
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller with a behavioural instruction memory and
// a queue of expected fetch results.
module tb_icache_controller;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         read;
  logic [9:0]   address;
  logic         busywait;
  logic [31:0]  ins_word0, ins_word1, ins_word2, ins_word3;
  logic [1:0]   offset;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int           n_vec = 0;
  int           n_err = 0;
  int           busy_n = 5;
  int           mem_cnt = 0;
  logic [31:0]  exp_q [$];

  always #5 CLK = ~CLK;

  icache_controller dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .read         (read),
    .address      (address),
    .busywait     (busywait),
    .ins_word0    (ins_word0),
    .ins_word1    (ins_word1),
    .ins_word2    (ins_word2),
    .ins_word3    (ins_word3),
    .offset       (offset),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  // Instruction memory contents per block address.
  function automatic logic [127:0] mem_block(input logic [5:0] b);
    logic [31:0] w [4];
    if (b == 6'd0) return 128'h0000000D_0000000C_0000000B_0000000A;
    for (int k = 0; k < 4; k++) w[k] = 32'hB000_0000 | (32'(b) << 8) | 32'(k);
    return {w[3], w[2], w[1], w[0]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    logic [127:0] blk;
    blk = mem_block(a[9:4]);
    return blk[32*a[3:2] +: 32];
  endfunction

  // Memory stays busy for busy_n cycles after mem_read rises.
  always @(posedge CLK) mem_cnt <= mem_read ? mem_cnt + 1 : 0;
  assign mem_busywait = mem_read && (mem_cnt < busy_n);
  assign mem_readdata = mem_block(mem_address);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Downstream word selector, modelled in the bench.
  function automatic logic [31:0] sel_word();
    case (offset)
      2'd0:    return ins_word0;
      2'd1:    return ins_word1;
      2'd2:    return ins_word2;
      default: return ins_word3;
    endcase
  endfunction

  // Issue a fetch, wait (bounded) for busywait to drop, check stall/memory cycles and word.
  task automatic fetch(input logic [9:0] a, input int exp_stall, input int exp_mrd,
                       input string tag);
    int   stall;
    int   mrd;
    logic addr_ok;
    logic [31:0] exp_w;
    read    = 1'b1;
    address = a;
    exp_q.push_back(mem_word(a));
    #1;
    stall   = 0;
    mrd     = 0;
    addr_ok = 1'b1;
    while (busywait === 1'b1 && stall < 60) begin
      if (mem_read === 1'b1) begin
        mrd++;
        if (mem_address !== a[9:4]) addr_ok = 1'b0;
      end
      stall++;
      tick();
    end
    chk({tag, ".stall"}, 128'(stall), 128'(exp_stall));
    chk({tag, ".mem_read_cycles"}, 128'(mrd), 128'(exp_mrd));
    chk({tag, ".mem_address"}, 128'(addr_ok), 128'(1));
    chk({tag, ".offset"}, 128'(offset), 128'(a[3:2]));
    exp_w = exp_q.pop_front();
    chk({tag, ".word"}, 128'(sel_word()), 128'(exp_w));
  endtask

  initial begin
    RESET   = 1'b1;
    read    = 1'b0;
    address = '0;
    tick();
    chk("reset.busywait", 128'(busywait), 128'(0));
    chk("reset.mem_read", 128'(mem_read), 128'(0));
    chk("reset.mem_address", 128'(mem_address), 128'(0));
    RESET = 1'b0;
    tick();

    // Cold miss: 5 busy cycles -> 6 mem_read cycles, 8 stall cycles.
    fetch(10'h000, 8, 6, "cold_000");
    chk("cold_000.word0", 128'(ins_word0), 128'(32'h0000000A));
    // Same block, last word: hit.
    fetch(10'h00C, 0, 0, "hit_00C");
    chk("hit_00C.word3", 128'(ins_word3), 128'(32'h0000000D));
    tick();

    // Conflict at index 0 with tag 1, then the original block misses again.
    fetch(10'h080, 8, 6, "conflict_080");
    tick();
    fetch(10'h000, 8, 6, "refill_000");
    tick();

    // Different index does not disturb index 0.
    fetch(10'h014, 8, 6, "fill_014");
    fetch(10'h000, 0, 0, "hit_000");
    fetch(10'h004, 0, 0, "hit_004");
    tick();

    // Reset on the second cycle of MemRead aborts the fill.
    read    = 1'b1;
    address = 10'h080;
    #1;
    chk("abort.miss_cycle0", 128'(busywait), 128'(1));
    tick();
    chk("abort.memread_cycle1", 128'(mem_read), 128'(1));
    tick();
    RESET = 1'b1;
    #1;
    chk("abort.busywait_forced", 128'(busywait), 128'(0));
    tick();
    chk("abort.mem_read_dropped", 128'(mem_read), 128'(0));
    chk("abort.busywait", 128'(busywait), 128'(0));
    RESET = 1'b0;
    read  = 1'b0;
    tick();
    fetch(10'h000, 8, 6, "after_abort_000");
    tick();

    // read=0: never stalls, never touches memory.
    read = 1'b0;
    for (int i = 0; i < 20; i++) begin
      address = 10'($urandom_range(0, 1023));
      #1;
      chk("idle.busywait", 128'(busywait), 128'(0));
      chk("idle.mem_read", 128'(mem_read), 128'(0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
